// File: rtl/fir_checker_if.sv
// fir_checker_if: groups the stream under observation (X, W, Y) and the checker's result outputs.
// Ports: X/W/Y come from the filter's driver side; MATCH..STATE are the checker's registered results.
// Modports: master = the driver/observer of results, slave = the checker itself.
interface fir_checker_if #(
   parameter int T  = 4,
   parameter int NI = 8,
   parameter int NO = 16
);
   logic signed [NI-1:0] X;
   logic [T*NI-1:0]      W;
   logic [NO-1:0]        Y;
   logic                 MATCH;
   logic                 FAIL;
   logic [31:0]          CHECKED;
   logic [15:0]          ERRORS;
   logic [31:0]          FIRST_IDX;
   logic [NO-1:0]        FIRST_EXP;
   logic [NO-1:0]        FIRST_GOT;
   logic [1:0]           STATE;

   modport master (
      output X, W, Y,
      input  MATCH, FAIL, CHECKED, ERRORS, FIRST_IDX, FIRST_EXP, FIRST_GOT, STATE
   );

   modport slave (
      input  X, W, Y,
      output MATCH, FAIL, CHECKED, ERRORS, FIRST_IDX, FIRST_EXP, FIRST_GOT, STATE
   );
endinterface

// File: rtl/fir_checker.sv
// fir_checker: rebuilds the FIR output from X/W with its own delay line and MAC and compares it with Y.
// Ports: CLK, RSTN (async active-low), bus (slave modport: X, W, Y in; MATCH, FAIL, counters, FIRST_*, STATE out).
// Latency: compare of Y at edge n against E_{n-LAT}; results registered, visible the cycle after the edge.
// Option: define FIR_CHECKER_HALT_ON_ERR_EN to freeze all results in HALT after the first mismatch.
module fir_checker #(
   parameter int T   = 4,
   parameter int NI  = 8,
   parameter int NO  = 16,
   parameter int LAT = 1
) (
   input  logic           CLK,
   input  logic           RSTN,
   fir_checker_if.slave   bus
);

   // Registered expected-value stages; LAT=1 compares straight against the MAC output.
   localparam int          SD       = (LAT > 1) ? LAT - 1 : 1;
   localparam logic [31:0] WARM_END = 32'(T + LAT - 1);

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      CHECK  = 2'd1
`ifdef FIR_CHECKER_HALT_ON_ERR_EN
      , HALT = 2'd2
`endif
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          n_q, n_next;
   logic signed [NI-1:0] h_q [T];
   logic [NO-1:0]        stage_q [SD];
   logic [NO-1:0]        e_comb, e_tail;
   logic                 do_cmp, hit;

   logic                 match_q, fail_q;
   logic [31:0]          checked_q, first_idx_q;
   logic [15:0]          errors_q;
   logic [NO-1:0]        first_exp_q, first_got_q;

   // Edge index of the edge about to happen; saturates instead of wrapping.
   assign n_next = (n_q == 32'hFFFF_FFFF) ? n_q : n_q + 32'd1;

   // MAC over the current history: each product sign-extended to NO, sum wraps mod 2^NO.
   always_comb begin
      logic signed [2*NI-1:0] prod;
      logic [NO-1:0]          acc;
      prod = '0;
      acc  = '0;
      for (int i = 0; i < T; i++) begin
         prod = (2*NI)'($signed(bus.W[i*NI +: NI])) * (2*NI)'(h_q[i]);
         acc  = acc + NO'(prod);
      end
      e_comb = acc;
   end

   assign e_tail = (LAT == 1) ? e_comb : stage_q[SD-1];

   always_comb begin
      state_d = state_q;
      do_cmp  = 1'b0;
      hit     = (bus.Y == e_tail);
      case (state_q)
         WARMUP: if (n_next == WARM_END) state_d = CHECK;
         CHECK: begin
            do_cmp = 1'b1;
`ifdef FIR_CHECKER_HALT_ON_ERR_EN
            if (!hit) state_d = HALT;
`endif
         end
`ifdef FIR_CHECKER_HALT_ON_ERR_EN
         HALT: state_d = HALT;
`endif
         default: state_d = WARMUP;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_q <= WARMUP;
      else       state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         n_q         <= '0;
         match_q     <= 1'b0;
         fail_q      <= 1'b0;
         checked_q   <= '0;
         errors_q    <= '0;
         first_idx_q <= '0;
         first_exp_q <= '0;
         first_got_q <= '0;
         for (int i = 0; i < T; i++)  h_q[i]     <= '0;
         for (int j = 0; j < SD; j++) stage_q[j] <= '0;
      end else begin
         n_q    <= n_next;
         // History keeps shifting in every state, including HALT.
         h_q[0] <= bus.X;
         for (int i = 1; i < T; i++) h_q[i] <= h_q[i-1];
         stage_q[0] <= e_comb;
         for (int j = 1; j < SD; j++) stage_q[j] <= stage_q[j-1];

         match_q <= do_cmp && hit;
         if (do_cmp) begin
            checked_q <= checked_q + 32'd1;
            if (!hit) begin
               if (errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
               fail_q <= 1'b1;
               if (!fail_q) begin
                  first_idx_q <= n_next;
                  first_exp_q <= e_tail;
                  first_got_q <= bus.Y;
               end
            end
         end
      end
   end

   assign bus.MATCH     = match_q;
   assign bus.FAIL      = fail_q;
   assign bus.CHECKED   = checked_q;
   assign bus.ERRORS    = errors_q;
   assign bus.FIRST_IDX = first_idx_q;
   assign bus.FIRST_EXP = first_exp_q;
   assign bus.FIRST_GOT = first_got_q;
   assign bus.STATE     = state_q;

endmodule

// File: doc/fir_checker.md
# fir_checker

Synthesizable self-checking monitor for the `fir` filter: observes the same sample stream `X` and coefficient set `W` that drive the filter, rebuilds the expected output with its own delay line and MAC, and compares it against the filter's `Y` after a fixed latency. Sits beside the filter instance, in benches or on silicon as a built-in self-test, and reports pass/fail, counters and the first mismatch.

## Interface

**Parameters**
- `T`, default 4: number of taps; must match the filter.
- `NI`, default 8: sample and coefficient width.
- `NO`, default 16 (2*NI): output width.
- `LAT`, default 1: filter latency in `CLK` edges, from an `X` sample to its `Y`; legal range 1–8.

**Ports** (name, direction, width, meaning)
- `CLK` in 1: clock; all state updates on the rising edge.
- `RSTN` in 1: reset, asynchronous, active-low.
- `X` in NI: filter input sample, signed two's complement.
- `W` in T×NI: coefficients, packed; `W[i]` is signed and applies to the sample i edges old.
- `Y` in NO: filter output under check.
- `MATCH` out 1: one-cycle pulse on a compared edge that matched.
- `FAIL` out 1: sticky; set on the first mismatch.
- `CHECKED` out 32: number of compared edges, wraps at 2^32.
- `ERRORS` out 16: mismatch count, saturates at 16'hFFFF.
- `FIRST_IDX` out 32: edge index n of the first mismatch.
- `FIRST_EXP` out NO: expected value at the first mismatch.
- `FIRST_GOT` out NO: `Y` value at the first mismatch.
- `STATE` out 2: current state; 0 = WARMUP, 1 = CHECK, 2 = HALT.

## Operation

- **Edge index.** n counts rising edges after `RSTN` deasserts; the first edge is n = 1. Internal counter is 32 bits and saturates.
- **History.** On each edge, `h[0]` ← `X` and `h[i]` ← `h[i-1]`. Reset clears `h` to 0.
- **Expected value.**
  - After edge n: E_n = Σ_{i<T} `W[i]`·`h[i]`.
  - Each product is NI×NI signed, sign-extended to NO; the sum is taken mod 2^NO.
  - E_n is pushed into an LAT-deep expected FIFO. The FIFO is a shift register with no backpressure.
- **Compare.** At edge n, `Y` is compared against E_{n-LAT}, the FIFO tail.
- **States.**
  - WARMUP: no compares. Moves to CHECK on the edge with n = T+LAT-1, so the first compare happens at n = T+LAT.
  - CHECK: compare on every edge.
    - Match: pulse `MATCH`.
    - Mismatch: increment `ERRORS` (saturating) and set `FAIL`.
    - First mismatch only: capture `FIRST_IDX`, `FIRST_EXP` and `FIRST_GOT`.
    - `CHECKED` increments on every compare.
  - HALT: reached only when the halt-on-error feature is compiled in (see Configuration). Counters, capture registers and `FAIL` are frozen; the history keeps shifting. The only exit is reset.
- **Coefficients.** `W` is sampled combinationally each edge. If `W` changes during CHECK, the mismatches that follow are counted normally; no masking.

## Timing

- **Reset values.** `STATE` = WARMUP, `MATCH` = 0, `FAIL` = 0, `CHECKED` = 0, `ERRORS` = 0, `FIRST_*` = 0, history and FIFO = 0.
- **Reset mid-run.** Asserting `RSTN` at any point, including mid-HALT, returns every register to its reset value immediately; warm-up restarts from n = 1.
- **Sampling.** `X` and `Y` are sampled on the rising `CLK` edge; both must be stable at that edge.
- **Output timing.** All outputs are registered.
  - `MATCH` is high for the single cycle following the compare edge.
  - `FAIL`, `ERRORS` and the `FIRST_*` registers update in that same cycle.
- **Simultaneous events.** A mismatch on the same edge where `ERRORS` is at saturation leaves `ERRORS` = FFFF; `FAIL` stays 1.
- **Counter wrap.** `CHECKED` wraps from FFFFFFFF to 0 without any side effect.

## Configuration

- Macro: `FIR_CHECKER_HALT_ON_ERR_EN`.
- **Defined:** on the first mismatch, `STATE` goes to HALT. That mismatch is still counted (`ERRORS` = 1, `CHECKED` includes it), and every later edge is ignored.
- **Undefined:** the HALT state is not built, `STATE` never equals 2, and checking continues indefinitely.

## Test plan

All scenarios use T=4, NI=8, NO=16, LAT=1, W = {-2, -1, 3, 4}, and X = (X+9)%19 from 0, giving 0, 9, 18, 8, 17, …

- **Reference match.** Drive the reference model's `Y` = E_{n-1}.
  - At n = 4, h = {8, 18, 9, 0} → E = 16'hFFF9; at n = 5, E = 16'h0030.
  - After 1000 edges: `CHECKED` = 996, `ERRORS` = 0, `FAIL` = 0, `MATCH` high on every compare.
- **Warm-up masking.** Drive `Y` = 16'hDEAD on edges 1–4, correct afterwards → `ERRORS` = 0, and the first `MATCH` appears after edge 5.
- **Single error injection.** Flip `Y` bit 3 at n = 20 only.
  - Response: `FAIL` = 1, `ERRORS` = 1, `FIRST_IDX` = 20, `FIRST_EXP` = E_19, `FIRST_GOT` = E_19 ^ 16'h0008.
  - Later compares all match.
- **Halt-on-error.** Macro defined, same injection at n = 20 plus another at n = 30.
  - Response: `STATE` = 2 from edge 20 onward, `ERRORS` = 1, `CHECKED` = 16 (frozen).
- **Mid-run reset.** Drive `RSTN` low during CHECK at n = 50 → all outputs return to reset values at once; compares resume at n = 5 counted from the release.
- **Error saturation.** Use a short force of `ERRORS` = 16'hFFFE, then three mismatches → `ERRORS` = FFFF and stays there; `FIRST_*` keeps the first capture.
